// File: rtl/ddl_fee_cmd_rx.sv
// DDL front-end bus receive side: decodes SIU-to-FEE control words into command pulses
// and buffers block-write data in a FIFO. Define DDL_RX_STATS_EN to enable rx_debug statistics.
module ddl_fee_cmd_rx #(
    parameter int FIFO_AW   = 6,
    parameter int LF_MARGIN = 4
) (
    input  logic        siu_foCLK,
    input  logic        siu_reset,
    input  logic [31:0] siu_fbd,
    input  logic        siu_fbten_n,
    input  logic        siu_fbctrl_n,
    input  logic        siu_fiben_n,
    input  logic        siu_fidir,
    output logic        siu_filf_n,
    output logic        rdo_open,
    output logic [3:0]  cmd_pulse,
    output logic [3:0]  cmd_tid,
    output logic [18:0] cmd_param,
    output logic [31:0] wr_dout,
    output logic        wr_empty,
    input  logic        wr_rd,
    output logic        wr_blk_done,
    output logic [7:0]  err_cnt,
    output logic [31:0] rx_debug
);
    localparam int CW = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0]      C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0]      C_MARGIN = CW'(LF_MARGIN);
    localparam logic [CW-1:0]      C_ONE    = CW'(1);
    localparam logic [FIFO_AW-1:0] P_ONE    = FIFO_AW'(1);
    localparam logic [3:0] C_RDYRX = 4'h1;
    localparam logic [3:0] C_EOBTR = 4'hB;
    localparam logic [3:0] C_STBWR = 4'hD;
    localparam logic [3:0] C_STBRD = 4'h5;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WR_BLK = 1'b1} state_t;

    state_t            r_state, w_state_nx;
    logic [31:0]       r_fbd, r_wr_data, r_dout;
    logic              r_fbten_n, r_fbctrl_n, r_fiben_n, r_fidir;
    logic              r_rdo_open, r_blk_done, r_wr_en, r_filf_n, r_empty;
    logic [3:0]        r_cmd_pulse, r_cmd_tid;
    logic [18:0]       r_cmd_param;
    logic [7:0]        r_err_cnt;
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0]     r_count, w_count_nx, w_free;
    logic [31:0]       r_mem [DEPTH];
    logic              w_valid, w_ctrl, w_data, w_rdo_nx, w_fsm_err, w_wr_req;
    logic              w_blk_done, w_cmd_acc, w_full, w_rd_do, w_wr_do, w_ovf;
    logic [3:0]        w_pulse;

    // Input stage: register all bus inputs once
    always_ff @(posedge siu_foCLK or posedge siu_reset) begin
        if (siu_reset) begin
            r_fbd      <= 32'h0;
            r_fbten_n  <= 1'b1;
            r_fbctrl_n <= 1'b1;
            r_fiben_n  <= 1'b1;
            r_fidir    <= 1'b1;
        end else begin
            r_fbd      <= siu_fbd;
            r_fbten_n  <= siu_fbten_n;
            r_fbctrl_n <= siu_fbctrl_n;
            r_fiben_n  <= siu_fiben_n;
            r_fidir    <= siu_fidir;
        end
    end

    assign w_valid = !r_fiben_n && !r_fidir && !r_fbten_n;
    assign w_ctrl  = w_valid && !r_fbctrl_n;
    assign w_data  = w_valid && r_fbctrl_n;

    // FSM state register
    always_ff @(posedge siu_foCLK or posedge siu_reset) begin
        if (siu_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Command decode, next state and per-word actions
    always_comb begin
        w_state_nx = r_state;
        w_pulse    = 4'b0000;
        w_rdo_nx   = r_rdo_open;
        w_fsm_err  = 1'b0;
        w_wr_req   = 1'b0;
        w_blk_done = 1'b0;
        w_cmd_acc  = 1'b0;
        if (w_ctrl) begin
            case (r_fbd[3:0])
                C_RDYRX: begin
                    w_pulse   = 4'b0001;
                    w_cmd_acc = 1'b1;
                    if (r_state == S_WR_BLK) begin
                        w_fsm_err  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_rdo_nx = 1'b1;
                    end
                end
                C_EOBTR: begin
                    w_pulse   = 4'b0010;
                    w_cmd_acc = 1'b1;
                    // Closing a write block leaves the readout level alone
                    if (r_state == S_WR_BLK) begin
                        w_blk_done = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_rdo_nx = 1'b0;
                    end
                end
                C_STBWR: begin
                    w_pulse    = 4'b0100;
                    w_cmd_acc  = 1'b1;
                    w_state_nx = S_WR_BLK;
                end
                C_STBRD: begin
                    w_pulse   = 4'b1000;
                    w_cmd_acc = 1'b1;
                    if (r_state == S_WR_BLK) begin
                        w_fsm_err  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                default: begin
                    w_fsm_err = 1'b1;
                end
            endcase
        end else if (w_data) begin
            if (r_state == S_WR_BLK) begin
                w_wr_req = 1'b1;
            end else begin
                w_fsm_err = 1'b1;
            end
        end else begin
            w_wr_req = 1'b0;
        end
    end

    // FIFO occupancy; a read frees a slot so a write at full is accepted alongside it
    assign w_full  = (r_count == C_DEPTH);
    assign w_rd_do = wr_rd && (r_count != {CW{1'b0}});
    assign w_wr_do = r_wr_en && (!w_full || w_rd_do);
    assign w_ovf   = r_wr_en && !w_wr_do;

    always_comb begin
        case ({w_wr_do, w_rd_do})
            2'b10:   w_count_nx = r_count + C_ONE;
            2'b01:   w_count_nx = r_count - C_ONE;
            default: w_count_nx = r_count;
        endcase
        w_free = C_DEPTH - w_count_nx;
    end

    // Command outputs, write pipeline, FIFO control and error counter
    always_ff @(posedge siu_foCLK or posedge siu_reset) begin
        if (siu_reset) begin
            r_cmd_pulse <= 4'b0000;
            r_cmd_tid   <= 4'h0;
            r_cmd_param <= 19'h0;
            r_rdo_open  <= 1'b0;
            r_blk_done  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= 32'h0;
            r_wptr      <= {FIFO_AW{1'b0}};
            r_rptr      <= {FIFO_AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_dout      <= 32'h0;
            r_empty     <= 1'b1;
            r_filf_n    <= 1'b1;
            r_err_cnt   <= 8'h00;
        end else begin
            r_cmd_pulse <= w_pulse;
            r_rdo_open  <= w_rdo_nx;
            r_blk_done  <= w_blk_done;
            r_wr_en     <= w_wr_req;
            r_wr_data   <= r_fbd;
            if (w_cmd_acc) begin
                r_cmd_tid   <= r_fbd[11:8];
                r_cmd_param <= r_fbd[30:12];
            end else begin
                r_cmd_tid   <= r_cmd_tid;
                r_cmd_param <= r_cmd_param;
            end
            if (w_wr_do) begin
                r_wptr <= r_wptr + P_ONE;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_rd_do) begin
                r_rptr <= r_rptr + P_ONE;
                r_dout <= r_mem[r_rptr];
            end else begin
                r_rptr <= r_rptr;
                r_dout <= r_dout;
            end
            r_count  <= w_count_nx;
            r_empty  <= (w_count_nx == {CW{1'b0}});
            r_filf_n <= (w_free > C_MARGIN);
            if ((w_fsm_err || w_ovf) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    // FIFO storage; contents are meaningless after reset because the pointers clear
    always_ff @(posedge siu_foCLK) begin
        if (w_wr_do) begin
            r_mem[r_wptr] <= r_wr_data;
        end
    end

`ifdef DDL_RX_STATS_EN
    logic [15:0] r_ctrl_cnt, r_data_cnt;

    // Saturating counts of accepted control words and stored data words
    always_ff @(posedge siu_foCLK or posedge siu_reset) begin
        if (siu_reset) begin
            r_ctrl_cnt <= 16'h0;
            r_data_cnt <= 16'h0;
        end else begin
            if (w_cmd_acc && (r_ctrl_cnt != 16'hFFFF)) begin
                r_ctrl_cnt <= r_ctrl_cnt + 16'h1;
            end else begin
                r_ctrl_cnt <= r_ctrl_cnt;
            end
            if (w_wr_do && (r_data_cnt != 16'hFFFF)) begin
                r_data_cnt <= r_data_cnt + 16'h1;
            end else begin
                r_data_cnt <= r_data_cnt;
            end
        end
    end

    assign rx_debug = {r_data_cnt, r_ctrl_cnt};
`else
    assign rx_debug = 32'h0;
`endif

    assign siu_filf_n  = r_filf_n;
    assign rdo_open    = r_rdo_open;
    assign cmd_pulse   = r_cmd_pulse;
    assign cmd_tid     = r_cmd_tid;
    assign cmd_param   = r_cmd_param;
    assign wr_dout     = r_dout;
    assign wr_empty    = r_empty;
    assign wr_blk_done = r_blk_done;
    assign err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_ddl_fee_cmd_rx.sv
// Scoreboard bench for ddl_fee_cmd_rx: stimulus pushes expected commands and FIFO reads,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_ddl_fee_cmd_rx;
    typedef struct packed {
        logic [3:0]  pulse;
        logic [3:0]  tid;
        logic [18:0] param;
    } cmd_t;

    logic        clk = 1'b0;
    logic        siu_reset = 1'b1;
    logic [31:0] siu_fbd = 32'h0;
    logic        siu_fbten_n = 1'b1;
    logic        siu_fbctrl_n = 1'b1;
    logic        siu_fiben_n = 1'b0;
    logic        siu_fidir = 1'b0;
    logic        wr_rd = 1'b0;
    logic        siu_filf_n, rdo_open, wr_empty, wr_blk_done;
    logic [3:0]  cmd_pulse, cmd_tid;
    logic [18:0] cmd_param;
    logic [31:0] wr_dout, rx_debug;
    logic [7:0]  err_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    int   blk_seen = 0;
    int   exp_blk = 0;
    logic rd_pend = 1'b0;
    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];

    always #5 clk = ~clk;

    ddl_fee_cmd_rx dut (
        .siu_foCLK(clk), .siu_reset(siu_reset), .siu_fbd(siu_fbd),
        .siu_fbten_n(siu_fbten_n), .siu_fbctrl_n(siu_fbctrl_n),
        .siu_fiben_n(siu_fiben_n), .siu_fidir(siu_fidir), .siu_filf_n(siu_filf_n),
        .rdo_open(rdo_open), .cmd_pulse(cmd_pulse), .cmd_tid(cmd_tid),
        .cmd_param(cmd_param), .wr_dout(wr_dout), .wr_empty(wr_empty),
        .wr_rd(wr_rd), .wr_blk_done(wr_blk_done), .err_cnt(err_cnt),
        .rx_debug(rx_debug)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each presented command pulse and each FIFO read against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (siu_reset) begin
                rd_pend = 1'b0;
            end else begin
                if (rd_pend) begin
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", wr_dout, 32'hxxxx_xxxx);
                    end else begin
                        check("rd_data", wr_dout, exp_rd.pop_front());
                    end
                end
                rd_pend = wr_rd;
                if (cmd_pulse != 4'b0000) begin
                    if (exp_cmd.size() == 0) begin
                        check("cmd_unexpected", {28'h0, cmd_pulse}, 32'h0);
                    end else begin
                        cmd_t e;
                        e = exp_cmd.pop_front();
                        check("cmd_pulse", {28'h0, cmd_pulse}, {28'h0, e.pulse});
                        check("cmd_tid", {28'h0, cmd_tid}, {28'h0, e.tid});
                        check("cmd_param", {13'h0, cmd_param}, {13'h0, e.param});
                    end
                end
                if (wr_blk_done) blk_seen++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        siu_reset = 1'b1;
        idle(2);
        siu_reset = 1'b0;
    endtask

    task automatic bus_word(input logic ctrl_n, input logic [31:0] d);
        siu_fbd      = d;
        siu_fbctrl_n = ctrl_n;
        siu_fbten_n  = 1'b0;
        idle(1);
        siu_fbten_n  = 1'b1;
    endtask

    task automatic send_cmd(input logic [31:0] d, input logic [3:0] pulse);
        cmd_t e;
        e.pulse = pulse;
        e.tid   = d[11:8];
        e.param = d[30:12];
        exp_cmd.push_back(e);
        bus_word(1'b0, d);
    endtask

    task automatic read_word(input logic [31:0] e);
        exp_rd.push_back(e);
        wr_rd = 1'b1;
        idle(1);
        wr_rd = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_filf_n", {31'h0, siu_filf_n}, 32'h1);
        check("rst_rdo_open", {31'h0, rdo_open}, 32'h0);
        check("rst_cmd_pulse", {28'h0, cmd_pulse}, 32'h0);
        check("rst_cmd_tid", {28'h0, cmd_tid}, 32'h0);
        check("rst_cmd_param", {13'h0, cmd_param}, 32'h0);
        check("rst_wr_dout", wr_dout, 32'h0);
        check("rst_wr_empty", {31'h0, wr_empty}, 32'h1);
        check("rst_blk_done", {31'h0, wr_blk_done}, 32'h0);
        check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        check("rst_rx_debug", rx_debug, 32'h0);
    endtask

    initial begin
        #7;
        check_reset_vals();
        do_reset();

        // RDYRX then EOBTR, with exact two-cycle latency on rdo_open
        send_cmd(32'h0000_0001, 4'b0001);
        @(negedge clk);
        check("rdyrx_early", {31'h0, rdo_open}, 32'h0);
        @(negedge clk);
        check("rdyrx_rdo", {31'h0, rdo_open}, 32'h1);
        check("rdyrx_pulse", {28'h0, cmd_pulse}, 32'h1);
        idle(1);
        send_cmd(32'h0000_000B, 4'b0010);
        idle(3);
        check("eobtr_rdo", {31'h0, rdo_open}, 32'h0);

        // STBWR tid 3, five data words, EOBTR, read back
        send_cmd(32'h0004_030D, 4'b0100);
        for (int i = 0; i < 5; i++) bus_word(1'b1, 32'hA0 + i);
        check("stbwr_tid", {28'h0, cmd_tid}, 32'h3);
        check("stbwr_param", {13'h0, cmd_param}, 32'h40);
        send_cmd(32'h0000_000B, 4'b0010);
        exp_blk++;
        idle(4);
        check("blk_done_cnt", blk_seen, exp_blk);
        check("blk_rdo", {31'h0, rdo_open}, 32'h0);
        for (int i = 0; i < 5; i++) read_word(32'hA0 + i);
        idle(3);
        check("blk_empty", {31'h0, wr_empty}, 32'h1);
        check("blk_err", {24'h0, err_cnt}, 32'h0);

        // Fill past full: link-full threshold at 60 words, two overflow drops
        do_reset();
        send_cmd(32'h0000_000D, 4'b0100);
        for (int i = 0; i < 59; i++) bus_word(1'b1, 32'h1000_0000 + i);
        idle(4);
        check("filf_59", {31'h0, siu_filf_n}, 32'h1);
        bus_word(1'b1, 32'h1000_0000 + 59);
        idle(4);
        check("filf_60", {31'h0, siu_filf_n}, 32'h0);
        for (int i = 60; i < 66; i++) bus_word(1'b1, 32'h1000_0000 + i);
        idle(4);
        check("ovf_err", {24'h0, err_cnt}, 32'h2);
        check("ovf_nonempty", {31'h0, wr_empty}, 32'h0);
        for (int i = 0; i < 10; i++) read_word(32'h1000_0000 + i);
        idle(3);
        check("filf_drain", {31'h0, siu_filf_n}, 32'h1);
        for (int i = 10; i < 64; i++) read_word(32'h1000_0000 + i);
        idle(3);
        check("full_drained", {31'h0, wr_empty}, 32'h1);
        check("full_err", {24'h0, err_cnt}, 32'h2);

        // Data in IDLE and an unknown code are errors; state and rdo_open kept
        do_reset();
        send_cmd(32'h0000_0001, 4'b0001);
        for (int i = 0; i < 3; i++) bus_word(1'b1, 32'hDEAD_0000 + i);
        bus_word(1'b0, 32'h0000_0007);
        idle(4);
        check("idle_err", {24'h0, err_cnt}, 32'h4);
        check("idle_empty", {31'h0, wr_empty}, 32'h1);
        check("idle_rdo", {31'h0, rdo_open}, 32'h1);

        // Turnaround inside WR_BLK: nothing valid, block survives
        send_cmd(32'h0004_030D, 4'b0100);
        idle(2);
        siu_fidir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            siu_fbten_n  = 1'b0;
            siu_fbctrl_n = i[0];
            siu_fbd      = i[0] ? 32'hAAAA_AAAA : 32'h5555_555B;
            idle(1);
        end
        siu_fbten_n = 1'b1;
        siu_fidir   = 1'b0;
        idle(4);
        check("ta_empty", {31'h0, wr_empty}, 32'h1);
        check("ta_err", {24'h0, err_cnt}, 32'h4);
        bus_word(1'b1, 32'hC0);
        bus_word(1'b1, 32'hC1);
        idle(4);
        check("ta_stored", {31'h0, wr_empty}, 32'h0);
        read_word(32'hC0);
        read_word(32'hC1);
        idle(3);
        check("ta_drained", {31'h0, wr_empty}, 32'h1);
        check("ta_err_after", {24'h0, err_cnt}, 32'h4);

        // Asynchronous reset mid-block with 10 words stored
        for (int i = 0; i < 10; i++) bus_word(1'b1, 32'hE000_0000 + i);
        idle(4);
        check("mid_stored", {31'h0, wr_empty}, 32'h0);
        #2;
        siu_reset = 1'b1;
        #1;
        check_reset_vals();
        idle(1);
        siu_reset = 1'b0;
        bus_word(1'b1, 32'hF0);
        idle(4);
        check("post_rst_err", {24'h0, err_cnt}, 32'h1);
        check("post_rst_empty", {31'h0, wr_empty}, 32'h1);

        check("cmd_queue_left", exp_cmd.size(), 32'h0);
        check("rd_queue_left", exp_rd.size(), 32'h0);
        check("blk_done_final", blk_seen, exp_blk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/ddl_fee_cmd_rx.md
Name: ddl_fee_cmd_rx

Overview:
- Receive side of the DDL front-end bus: decodes SIU-to-FEE traffic, i.e. traffic while the SIU owns the bus (siu_fidir=0, siu_fiben_n=0).
- Decodes RORC control words (RDYRX, EOBTR, STBWR, STBRD) into command pulses and a readout-open level.
- Buffers block-write data words in an internal FIFO and throttles the SIU through siu_filf_n.
- Sits beside the FEE-side transmit interface on the same siu_foCLK domain and feeds the SRU configuration logic.

Parameters:
- FIFO_AW, 6, FIFO address width; depth is 2**FIFO_AW words.
- LF_MARGIN, 4, free-word margin at which siu_filf_n asserts; it covers the SIU in-flight latency.

Ports:
- siu_foCLK  in  1  bus clock; the only clock.
- siu_reset  in  1  asynchronous reset, active-high.
- siu_fbd  in  32  front-end bus data.
- siu_fbten_n  in  1  transfer enable, active-low.
- siu_fbctrl_n  in  1  0 = control word, 1 = data word.
- siu_fiben_n  in  1  bus enable, active-low.
- siu_fidir  in  1  0 = SIU to FEE.
- siu_filf_n  out  1  link-full to SIU, active-low.
- rdo_open  out  1  readout open (set by RDYRX, cleared by EOBTR).
- cmd_pulse  out  4  one-hot, one cycle: {STBRD, STBWR, EOBTR, RDYRX}.
- cmd_tid  out  4  transaction id of the last accepted command.
- cmd_param  out  19  parameter field fbd[30:12] of the last accepted command.
- wr_dout  out  32  FIFO read data.
- wr_empty  out  1  FIFO empty.
- wr_rd  in  1  FIFO read strobe.
- wr_blk_done  out  1  one cycle: EOBTR closed a write block.
- err_cnt  out  8  saturating protocol-error counter.
- rx_debug  out  32  statistics (see Optional Feature).

Behaviour:
- Reset values: siu_filf_n=1, rdo_open=0, cmd_pulse=0, cmd_tid=0, cmd_param=0, wr_dout=0, wr_empty=1, wr_blk_done=0, err_cnt=0, rx_debug=0; FIFO pointers=0; FSM in IDLE.
- Input stage: all bus inputs registered once.
- Valid word: registered fiben_n=0 && fidir=0 && fbten_n=0.
- Control word: valid word with fbctrl_n=0. Code = fbd[3:0]; tid = fbd[11:8].
- Decoded codes: RDYRX=4'h1, EOBTR=4'hB, STBWR=4'hD, STBRD=4'h5.
- Latency: cmd_pulse, cmd_tid and cmd_param update 2 cycles after the word is on the bus.
- FSM states:
  - IDLE: RDYRX sets rdo_open. STBWR goes to WR_BLK. STBRD pulses only; no state change. EOBTR clears rdo_open.
  - WR_BLK: each valid data word is written to the FIFO. EOBTR pulses wr_blk_done and cmd_pulse[1], then returns to IDLE; rdo_open is not changed by this EOBTR. RDYRX or STBRD in WR_BLK counts as an error, is still pulsed, and returns to IDLE.
  - While not in WR_BLK, a data word is dropped and counted as an error.
  - An unknown control code is dropped, counted as an error, and leaves state unchanged.
- FIFO:
  - Write data lands at the FIFO input 1 cycle after registration.
  - wr_rd with non-empty FIFO: wr_dout is valid the next cycle. wr_rd when empty is ignored.
  - Simultaneous read and write at full or at empty are both legal; the occupancy count stays exact.
  - Pointers wrap modulo depth.
- Overflow: a write while full drops the word, counts an error, and leaves the FIFO intact.
- siu_filf_n: 0 when free words <= LF_MARGIN; returns to 1 when free words > LF_MARGIN. Registered.
- err_cnt: saturates at 8'hFF; +1 per error event, at most 1 per cycle.
- Bus turnaround: siu_fidir=1 or siu_fiben_n=1 means no valid words. The FSM state is held; WR_BLK survives a turnaround.
- Reset mid-operation: asynchronous clear of everything listed above; FIFO contents are discarded.

Optional Feature:
- Macro: DDL_RX_STATS_EN.
- Defined:
  - rx_debug[15:0] = saturating count of accepted control words.
  - rx_debug[31:16] = saturating count of data words written to the FIFO.
  - Both counters clear on siu_reset.
- Not defined: rx_debug is tied to 32'h0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- RDYRX then EOBTR (fbd=32'h0000_0001, then 32'h0000_000B, each with fbctrl_n=0):
  - cmd_pulse=4'b0001, then rdo_open=1, 2 cycles after the first word.
  - cmd_pulse=4'b0010, then rdo_open=0.
- STBWR with tid 3 and param 19'h00040 (fbd=32'h0004_030D), then 5 data words 32'hA0..A4, then EOBTR:
  - cmd_tid=4'h3, cmd_param=19'h00040.
  - wr_blk_done pulses once.
  - Reading the FIFO returns A0..A4 in order, then wr_empty=1.
- STBWR, then 2**FIFO_AW+2 data words with wr_rd=0:
  - siu_filf_n goes 0 at 60 stored words (default parameters).
  - FIFO holds 64 words; err_cnt=2.
  - Draining 10 words sets siu_filf_n=1.
- 3 data words in IDLE plus one unknown code 4'h7 -> err_cnt=4, FIFO empty, state unchanged.
- In WR_BLK, siu_fidir=1 for 20 cycles with data toggling on siu_fbd -> no FIFO writes; data words after fidir returns to 0 are still accepted.
- Assert siu_reset mid-block with 10 words stored:
  - All outputs return to reset values immediately.
  - A subsequent data word is counted as an error (FSM is back in IDLE).
